// File: rtl/mouse_axis_pkg.sv
// Shared types, bus field positions and arithmetic helpers for the mouse-to-analog-stick emulator.
package mouse_axis_pkg;

  localparam int AW_DEF = 8;
  localparam int DW     = 9;

  localparam int MB_TOG = 24;
  localparam int MB_XD  = 8;
  localparam int MB_YD  = 16;
  localparam int MB_XS  = 4;
  localparam int MB_YS  = 5;
  localparam int MB_BTN = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMU  = 1'b1
  } port_state_e;

  // Signed add, saturated to the range of a w-bit two's complement value.
  function automatic int sat_add(input int a, input int b, input int w);
    int s;
    int hi;
    int lo;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    s  = a + b;
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

  function automatic int toward_zero(input int a, input int step);
    if (a > step) return a - step;
    if (a < -step) return a + step;
    return 0;
  endfunction

endpackage

// File: rtl/mouse_axis_acc.sv
// One emulated axis: mouse delta shift/clamp/invert feeding a saturating position accumulator
// with clear and an optional recentring decay request.
module mouse_axis_acc
  import mouse_axis_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int SENS_SHIFT = 1,
  parameter int DCLAMP     = 10,
  parameter int DECAY_STEP = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_clear,
  input  logic          i_event,
  input  logic          i_decay,
  input  logic [7:0]    i_data,
  input  logic          i_sign,
  input  logic          i_invert,
  output logic [AW-1:0] o_acc
);

  logic signed [DW-1:0] w_raw;
  logic signed [31:0]   w_d;
  logic signed [31:0]   w_cl;
  logic signed [31:0]   w_dl;
  logic signed [31:0]   w_acc32;
  logic signed [31:0]   w_sum;
  logic signed [31:0]   w_dec;
  logic signed [AW:0]   r_acc;
  logic                 r_decay_pend;
  logic                 w_unused;

  assign w_raw = {i_sign, i_data};

  always_comb begin
    w_d  = 32'(w_raw) >>> SENS_SHIFT;
    w_cl = w_d;
    if (w_d > DCLAMP) begin
      w_cl = DCLAMP;
    end else if (w_d < -DCLAMP) begin
      w_cl = -DCLAMP;
    end
  end

  assign w_dl    = i_invert ? -w_cl : w_cl;
  assign w_acc32 = 32'(r_acc);
  assign w_sum   = sat_add(w_acc32, w_dl, AW);
  assign w_dec   = toward_zero(w_acc32, DECAY_STEP);

  // A decay request that lands on a report cycle is deferred by one cycle.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_acc        <= '0;
      r_decay_pend <= 1'b0;
    end else if (i_event) begin
      r_acc        <= w_sum[AW:0];
      r_decay_pend <= i_decay;
    end else begin
      if (i_decay || r_decay_pend) begin
        r_acc <= w_dec[AW:0];
      end
      r_decay_pend <= 1'b0;
    end
  end

  assign o_acc    = r_acc[AW-1:0];
  assign w_unused = ^{w_sum[31:AW+1], w_dec[31:AW+1]};

endmodule

// File: rtl/mouse_axis_emu.sv
// Mouse-to-analog-stick emulator for NCH joystick ports in the video clock domain.
// Define MOUSE_AXIS_DECAY_EN to recentre the emulated stick on each vblank rising edge.
module mouse_axis_emu
  import mouse_axis_pkg::*;
#(
  parameter int NCH        = 4,
  parameter int AW         = AW_DEF,
  parameter int SENS_SHIFT = 1,
  parameter int DCLAMP     = 10,
  parameter int DECAY_STEP = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [24:0]         ps2_mouse,
  input  logic                vblank,
  input  logic [2:0]          target_sel,
  input  logic                invert_x,
  input  logic                invert_y,
  input  logic                halt,
  input  logic [NCH*16-1:0]   joya_in,
  output logic [NCH*AW-1:0]   ax_out,
  output logic [NCH*AW-1:0]   ay_out,
  output logic [NCH*2-1:0]    mbtn_out,
  output logic [NCH-1:0]      emu_active
);

  logic              r_tog_s1;
  logic              r_tog_s2;
  logic              r_tog_ref;
  logic [2:0]        r_sel_prev;
  logic [1:0]        r_btn;
  logic              w_event;
  logic              w_sel_chg;
  logic              w_sel_valid;
  logic              w_acc_clr;
  logic              w_acc_evt;
  logic              w_decay;
  logic              w_unused;
  logic [NCH-1:0]    w_sel_oh;
  logic [NCH-1:0]    w_joy_nz;
  logic [NCH-1:0]    w_emu;
  logic [AW-1:0]     w_acc_x;
  logic [AW-1:0]     w_acc_y;
  logic [NCH*AW-1:0] w_ax_nx;
  logic [NCH*AW-1:0] w_ay_nx;
  logic [NCH*2-1:0]  w_btn_nx;

  // Sync chain runs through reset so the reference tracks any toggle edge seen during it.
  always_ff @(posedge clk) begin
    r_tog_s1   <= ps2_mouse[MB_TOG];
    r_tog_s2   <= r_tog_s1;
    r_tog_ref  <= r_tog_s2;
    r_sel_prev <= target_sel;
  end

  assign w_event     = r_tog_s2 ^ r_tog_ref;
  assign w_sel_chg   = target_sel != r_sel_prev;
  assign w_sel_valid = |w_sel_oh;
  assign w_acc_clr   = halt | w_sel_chg | ~w_sel_valid | (|(w_joy_nz & w_sel_oh));
  assign w_acc_evt   = w_event & ~w_acc_clr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_btn <= 2'b00;
    end else if (w_acc_evt) begin
      r_btn <= ps2_mouse[MB_BTN +: 2];
    end
  end

`ifdef MOUSE_AXIS_DECAY_EN
  logic r_vb_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vb_prev <= 1'b0;
    end else begin
      r_vb_prev <= vblank;
    end
  end

  assign w_decay  = vblank & ~r_vb_prev & (|(w_emu & w_sel_oh));
  assign w_unused = ^{ps2_mouse[7:6], ps2_mouse[3:2]};
`else
  assign w_decay  = 1'b0;
  assign w_unused = ^{ps2_mouse[7:6], ps2_mouse[3:2], vblank};
`endif

  mouse_axis_acc #(
    .AW(AW), .SENS_SHIFT(SENS_SHIFT), .DCLAMP(DCLAMP), .DECAY_STEP(DECAY_STEP)
  ) u_acc_x (
    .clk(clk), .reset(reset), .i_clear(w_acc_clr), .i_event(w_acc_evt), .i_decay(w_decay),
    .i_data(ps2_mouse[MB_XD +: 8]), .i_sign(ps2_mouse[MB_XS]), .i_invert(invert_x),
    .o_acc(w_acc_x)
  );

  mouse_axis_acc #(
    .AW(AW), .SENS_SHIFT(SENS_SHIFT), .DCLAMP(DCLAMP), .DECAY_STEP(DECAY_STEP)
  ) u_acc_y (
    .clk(clk), .reset(reset), .i_clear(w_acc_clr), .i_event(w_acc_evt), .i_decay(w_decay),
    .i_data(ps2_mouse[MB_YD +: 8]), .i_sign(ps2_mouse[MB_YS]), .i_invert(invert_y),
    .o_acc(w_acc_y)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_port
      port_state_e r_state;
      port_state_e w_state_next;
      logic        w_clr;
      logic [7:0]  w_jx;
      logic [7:0]  w_jy;
      logic [AW-1:0] w_jx_aw;
      logic [AW-1:0] w_jy_aw;

      assign w_jx          = joya_in[gi*16 +: 8];
      assign w_jy          = joya_in[gi*16+8 +: 8];
      assign w_sel_oh[gi]  = target_sel == 3'(gi);
      assign w_joy_nz[gi]  = |joya_in[gi*16 +: 16];
      assign w_clr         = w_joy_nz[gi] | halt | w_sel_chg;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_state <= ST_IDLE;
        end else begin
          r_state <= w_state_next;
        end
      end

      always_comb begin
        w_state_next = r_state;
        case (r_state)
          ST_IDLE: if (!w_clr && w_event && w_sel_oh[gi]) w_state_next = ST_EMU;
          ST_EMU:  if (w_clr) w_state_next = ST_IDLE;
        endcase
      end

      assign w_emu[gi] = r_state == ST_EMU;

      if (AW >= 8) begin : g_ext
        assign w_jx_aw = {{(AW-7){w_jx[7]}}, w_jx[6:0]};
        assign w_jy_aw = {{(AW-7){w_jy[7]}}, w_jy[6:0]};
      end else begin : g_trunc
        assign w_jx_aw = w_jx[AW-1:0];
        assign w_jy_aw = w_jy[AW-1:0];
      end

      assign w_ax_nx[gi*AW +: AW] = w_emu[gi] ? w_acc_x : w_jx_aw;
      assign w_ay_nx[gi*AW +: AW] = w_emu[gi] ? w_acc_y : w_jy_aw;
      assign w_btn_nx[gi*2 +: 2]  = w_emu[gi] ? r_btn : 2'b00;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      ax_out     <= '0;
      ay_out     <= '0;
      mbtn_out   <= '0;
      emu_active <= '0;
    end else begin
      ax_out     <= w_ax_nx;
      ay_out     <= w_ay_nx;
      mbtn_out   <= w_btn_nx;
      emu_active <= w_emu;
    end
  end

endmodule

// File: doc/mouse_axis_emu.md
Name: mouse_axis_emu

Overview:
- Parametrised mouse-to-analog-stick emulator for the console cores; successor to the single-port inline mouse/axis logic in the 5200 top level.
- Converts PS/2 mouse reports into saturated absolute X/Y positions for any one of NCH analog joystick ports, with mouse buttons mapped to fire.
- Real analog input on a port overrides emulation.
- Lives in the CLK_VIDEO domain so frame-based recentring can use VBlank; the mouse bus arrives from clk_sys through a toggle synchroniser.

Parameters:
- NCH, 4, number of analog ports served (1..8)
- AW, 8, output axis width in bits (signed two's complement)
- SENS_SHIFT, 1, arithmetic right shift applied to the raw 9-bit mouse delta
- DCLAMP, 10, per-report delta magnitude clamp after the shift
- DECAY_STEP, 2, per-frame recentring step; used only with the optional feature

Ports:
- clk  in  1  CLK_VIDEO
- reset  in  1  synchronous, active-high
- ps2_mouse  in  25  clk_sys-domain mouse bus: [24] toggle strobe, [15:8] X data, [23:16] Y data, [4]/[5] X/Y sign, [1:0] buttons
- vblank  in  1  CLK_VIDEO-domain vertical blank
- target_sel  in  3  port index driven by the mouse; values >= NCH disable emulation
- invert_x  in  1  negate X deltas
- invert_y  in  1  negate Y deltas
- halt  in  1  CPU halt (OSD or loader active); clears emulation
- joya_in  in  NCH*16  real analog input per port: [7:0] X, [15:8] Y
- ax_out  out  NCH*AW  per-port X output
- ay_out  out  NCH*AW  per-port Y output
- mbtn_out  out  NCH*2  per-port mouse buttons; zero when the port is not emulated
- emu_active  out  NCH  per-port emulation flag

Behaviour:
- Reset state:
  - All outputs 0.
  - Accumulators 0.
  - Toggle reference is loaded from the synchronised toggle, so a toggle change during reset does not produce an event.
- Synchroniser:
  - ps2_mouse[24] passes through 2 flip-flops.
  - An event occurs when the synchronised toggle differs from the registered reference.
  - On an event, sample the data bits directly. The source holds the data stable for at least 4 CLK_VIDEO cycles after the toggle changes.
- Delta path:
  - d = signed 9-bit {sign, data[7:0]}.
  - Apply d >>> SENS_SHIFT.
  - Clamp to [-DCLAMP, +DCLAMP].
  - Negate if the invert input is set.
  - Y delta is positive up, matching the legacy core.
- Accumulator:
  - Signed AW+1 bits.
  - new = acc + delta, saturated to [-2^(AW-1), 2^(AW-1)-1].
  - There is one X/Y accumulator pair only, belonging to the selected port.
- Per-port FSM, with states IDLE, EMU:
  - IDLE -> EMU on an event while target_sel == port.
  - EMU -> IDLE, with the accumulator zeroed, on any of:
    - joya_in[port] != 0
    - halt
    - target_sel change
- Priority: reset > clear (joya/halt/sel change) > event update. An event in the same cycle as a clear is dropped.
- Output mux, registered:
  - Emulated port: ax_out = acc[AW-1:0], mbtn_out = buttons.
  - Other ports: ax_out = joya_in X, sign-extended or truncated to AW.
- Latency: a toggle change at the input appears on ax_out/ay_out after 4 CLK_VIDEO edges (2 sync + event/accumulate + output register).
- Back-to-back events: each distinct toggle edge is processed once. If reports arrive faster than 4 CLK_VIDEO cycles apart, that is outside specification.

Optional Feature:
- Macro: MOUSE_AXIS_DECAY_EN.
- Enabled:
  - Each vblank rising edge moves an EMU accumulator toward 0 by DECAY_STEP, stopping at 0 without crossing.
  - If an event coincides with the edge, the event applies first and the decay is held pending for the next cycle.
  - Decay is not applied in IDLE.
- Disabled: position holds indefinitely; vblank is ignored.

Decomposition:
- Shared package mouse_axis_pkg:
  - AW default
  - delta width constant (9)
  - sat_add function (signed add with saturation to a given width)
  - mouse bus field index localparams
- Sub-module mouse_axis_acc: one axis with delta shift/clamp/invert, saturating accumulator, clear and optional decay. Instantiated twice (X, Y).
- The top level holds the synchroniser, per-port FSM and output mux.

Test Plan:
- Reset, then NCH=4, target_sel=0, one report X=+0x40 sign=0 -> after 4 edges ax_out[0]=+10 (0x40>>>1=32, clamped to 10), emu_active=4'b0001, ports 1-3 pass joya_in.
- 20 reports of X=+0x40 -> ax_out[0] saturates at 127 and holds. 30 reports of X=-0x40 -> ax_out[0]=-128.
- EMU on port 0, then joya_in[0]=16'h0010 -> next cycle emu_active[0]=0, ax_out[0]=0x10, accumulator 0; subsequent report re-enters EMU from 0.
- target_sel changed 0->2 mid-motion -> port 0 returns to joya_in, next report drives port 2 from 0. target_sel=5 -> no port emulated.
- Toggle change asserted during reset, reset released -> no event, outputs stay 0. Event in the same cycle as halt -> dropped, EMU cleared.
- With MOUSE_AXIS_DECAY_EN and acc=+5, DECAY_STEP=2 -> three vblank edges give 3, 1, 0. Event coincident with an edge -> event applied, then decay one cycle later.
